serial_link_credit_vc_sync: RTL and testbench

Multi-virtual-channel credit-based flow control for the serial link transmit path. It keeps one pair of credit counters per virtual channel (VC) and arbitrates the VC data streams round-robin onto a single link flit stream. Each flit carries returned credits for one VC; credit-only flits are generated when returned credits pile up. It sits between the per-VC transmit queues and the link framing layer, and receives credit and consumption events from the receive path.

---
 rtl/serial_link_pkg.sv | 30 +++
 rtl/serial_link_vc_credit_counter.sv | 51 +++++
 rtl/serial_link_credit_vc_sync.sv | 198 +++++++++++++++++++
 tb/tb_serial_link_credit_vc_sync.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial link credit / virtual-channel logic.
// Header fields are sized for the largest supported configuration; the top
// narrows them to its own VcWidth / CreditWidth on the ports.
package serial_link_pkg;

    localparam int unsigned MaxVcWidth     = 8;
    localparam int unsigned MaxCreditWidth = 8;

    typedef logic [MaxVcWidth-1:0]     vc_idx_t;
    typedef logic [MaxCreditWidth-1:0] credit_t;

    // Header that travels alongside every flit payload.
    typedef struct packed {
        vc_idx_t vc;
        logic    credit_only;
        vc_idx_t credit_vc;
        credit_t credits;
    } flit_hdr_t;

    // Index width that stays at least one bit for a single channel.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

    // A force-send threshold must be reachable and non-zero.
    function automatic logic thresh_ok(input int unsigned thresh, input int unsigned num_credits);
        return (thresh > 0) && (thresh <= num_credits);
    endfunction

endpackage

// File: rtl/serial_link_vc_credit_counter.sv
// One virtual channel's credit state: avail = remote buffer space we may use,
// pend = local buffer entries freed but not yet reported to the remote side.
// All events of a cycle are folded into a single update of each counter.
module serial_link_vc_credit_counter
    import serial_link_pkg::*;
#(
    parameter int unsigned NumCredits  = 8,
    parameter int unsigned CreditWidth = $clog2(NumCredits + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   data_load_i,
    input  logic                   rx_credit_i,
    input  logic [CreditWidth-1:0] rx_credits_i,
    input  logic                   take_i,
    input  logic [CreditWidth-1:0] take_credits_i,
    input  logic                   consume_i,
    output logic [CreditWidth-1:0] avail_o,
    output logic [CreditWidth-1:0] pend_o
);

    logic [CreditWidth-1:0] avail_q, avail_d;
    logic [CreditWidth-1:0] pend_q, pend_d;

    // Combine data use, returned credits, credit snapshot and consumption.
    always_comb begin
        avail_d = avail_q - CreditWidth'(data_load_i);
        if (rx_credit_i) begin
            avail_d = avail_d + rx_credits_i;
        end
        pend_d = pend_q + CreditWidth'(consume_i);
        if (take_i) begin
            pend_d = pend_d - take_credits_i;
        end
    end

    // Counter registers; remote buffer starts full-empty (all credits ours).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            avail_q <= CreditWidth'(NumCredits);
            pend_q  <= '0;
        end else begin
            avail_q <= avail_d;
            pend_q  <= pend_d;
        end
    end

    assign avail_o = avail_q;
    assign pend_o  = pend_q;

endmodule

// File: rtl/serial_link_credit_vc_sync.sv
// Multi-VC credit flow control on the serial link transmit path.
// Round-robin arbitration of per-VC streams onto one registered flit output;
// every flit piggybacks the largest pending credit count of any VC.
// Optional feature macro: SERIAL_LINK_CREDIT_FORCE_SEND_EN enables credit-only
// flits once pending credits reach ForceSendThresh.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high; link_* holds every field stable while link_valid_o is high and
// link_ready_i is low, and vc_ready_o is only raised for a VC whose valid is high.
module serial_link_credit_vc_sync
    import serial_link_pkg::*;
#(
    parameter int unsigned NumVc           = 2,
    parameter int unsigned NumCredits      = 8,
    parameter int unsigned ForceSendThresh = NumCredits - 2,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned CreditWidth     = $clog2(NumCredits + 1),
    parameter int unsigned VcWidth         = idx_width(NumVc)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumVc-1:0]                vc_valid_i,
    output logic [NumVc-1:0]                vc_ready_o,
    input  logic [NumVc-1:0][DataWidth-1:0] vc_data_i,
    output logic                            link_valid_o,
    input  logic                            link_ready_i,
    output logic [DataWidth-1:0]            link_data_o,
    output logic [VcWidth-1:0]              link_vc_o,
    output logic                            link_credit_only_o,
    output logic [VcWidth-1:0]              link_credit_vc_o,
    output logic [CreditWidth-1:0]          link_credits_o,
    input  logic                            rx_credit_valid_i,
    input  logic [VcWidth-1:0]              rx_credit_vc_i,
    input  logic [CreditWidth-1:0]          rx_credits_i,
    input  logic [NumVc-1:0]                rx_consume_i
);

    logic [NumVc-1:0][CreditWidth-1:0] avail;
    logic [NumVc-1:0][CreditWidth-1:0] pend;
    logic [NumVc-1:0][CreditWidth:0]   eff_avail;
    logic [NumVc-1:0]                  eligible;

    logic [VcWidth-1:0]     sel_vc;
    logic [CreditWidth-1:0] sel_credits;
    logic                   any_elig;
    logic [VcWidth-1:0]     grant_vc;
    logic [DataWidth-1:0]   grant_data;
    logic [VcWidth-1:0]     rr_q;

    logic                 load_en;
    logic                 data_load;
    logic                 credit_load;
    logic                 any_load;
    logic                 valid_q;
    logic [DataWidth-1:0] data_q;
    flit_hdr_t            hdr_q;

    // Pick the VC owed the most credits; ties go to the lowest index.
    always_comb begin
        sel_vc      = '0;
        sel_credits = pend[0];
        for (int unsigned v = 1; v < NumVc; v++) begin
            if (pend[v] > sel_credits) begin
                sel_vc      = VcWidth'(v);
                sel_credits = pend[v];
            end
        end
    end

    // Eligibility sees this cycle's returned credits so an empty VC can be
    // granted in the same cycle its credits come back. The last credit is
    // only spent on a flit that returns credits, so neither side can starve.
    always_comb begin
        for (int unsigned v = 0; v < NumVc; v++) begin
            eff_avail[v] = {1'b0, avail[v]};
            if (rx_credit_valid_i && (rx_credit_vc_i == VcWidth'(v))) begin
                eff_avail[v] = eff_avail[v] + {1'b0, rx_credits_i};
            end
            eligible[v] = vc_valid_i[v] &&
                          ((eff_avail[v] > (CreditWidth + 1)'(1)) ||
                           ((eff_avail[v] == (CreditWidth + 1)'(1)) && (sel_credits != '0)));
        end
    end

    // Round-robin search starting at the priority pointer.
    always_comb begin
        int unsigned idx;
        any_elig = 1'b0;
        grant_vc = '0;
        for (int unsigned k = 0; k < NumVc; k++) begin
            idx = (32'(rr_q) + k) % NumVc;
            if (!any_elig && eligible[idx]) begin
                any_elig = 1'b1;
                grant_vc = VcWidth'(idx);
            end
        end
    end

    // Payload of the granted VC.
    always_comb begin
        grant_data = '0;
        for (int unsigned v = 0; v < NumVc; v++) begin
            if (grant_vc == VcWidth'(v)) begin
                grant_data = vc_data_i[v];
            end
        end
    end

    // The output register accepts a new flit when empty or being drained.
    assign load_en   = ~valid_q | link_ready_i;
    assign data_load = rst_ni & load_en & any_elig;
`ifdef SERIAL_LINK_CREDIT_FORCE_SEND_EN
    assign credit_load = rst_ni & load_en & ~any_elig &
                         (sel_credits >= CreditWidth'(ForceSendThresh));
`else
    assign credit_load = 1'b0;
`endif
    assign any_load = data_load | credit_load;

    // Accept strobe back to the granted VC queue.
    always_comb begin
        vc_ready_o = '0;
        for (int unsigned v = 0; v < NumVc; v++) begin
            vc_ready_o[v] = data_load && (grant_vc == VcWidth'(v));
        end
    end

    // Per-VC counter pairs.
    for (genvar v = 0; v < NumVc; v++) begin : g_vc
        serial_link_vc_credit_counter #(
            .NumCredits  (NumCredits),
            .CreditWidth (CreditWidth)
        ) u_cnt (
            .clk_i          (clk_i),
            .rst_ni         (rst_ni),
            .data_load_i    (data_load && (grant_vc == VcWidth'(v))),
            .rx_credit_i    (rx_credit_valid_i && (rx_credit_vc_i == VcWidth'(v))),
            .rx_credits_i   (rx_credits_i),
            .take_i         (any_load && (sel_vc == VcWidth'(v))),
            .take_credits_i (sel_credits),
            .consume_i      (rx_consume_i[v]),
            .avail_o        (avail[v]),
            .pend_o         (pend[v])
        );
    end

    // Flit output register and round-robin pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            hdr_q   <= '0;
            rr_q    <= '0;
        end else begin
            if (load_en) begin
                valid_q <= any_load;
            end
            if (any_load) begin
                data_q            <= data_load ? grant_data : '0;
                hdr_q.vc          <= data_load ? vc_idx_t'(grant_vc) : '0;
                hdr_q.credit_only <= credit_load;
                hdr_q.credit_vc   <= vc_idx_t'(sel_vc);
                hdr_q.credits     <= credit_t'(sel_credits);
            end
            if (data_load) begin
                rr_q <= (32'(grant_vc) == NumVc - 1) ? '0 : grant_vc + 1'b1;
            end
        end
    end

    assign link_valid_o     = valid_q;
    assign link_data_o      = data_q;
    assign link_vc_o        = hdr_q.vc[VcWidth-1:0];
    assign link_credit_vc_o = hdr_q.credit_vc[VcWidth-1:0];
    assign link_credits_o   = hdr_q.credits[CreditWidth-1:0];
`ifdef SERIAL_LINK_CREDIT_FORCE_SEND_EN
    assign link_credit_only_o = hdr_q.credit_only;
`else
    assign link_credit_only_o = 1'b0;
`endif

`ifndef SYNTHESIS
    a_thresh: assert property (@(posedge clk_i) thresh_ok(ForceSendThresh, NumCredits));

    for (genvar v = 0; v < NumVc; v++) begin : g_chk
        a_avail: assert property (@(posedge clk_i) disable iff (!rst_ni)
            32'(avail[v]) <= NumCredits);
        a_pend: assert property (@(posedge clk_i) disable iff (!rst_ni)
            32'(pend[v]) <= NumCredits);
    end

    a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (valid_q && !link_ready_i) |=> (valid_q && $stable(data_q) && $stable(hdr_q)));

    a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(vc_ready_o));
`endif

endmodule

// File: tb/tb_serial_link_credit_vc_sync.sv
// Bench for serial_link_credit_vc_sync: directed phases with hand-computed
// expectations, plus a per-cycle comparison against a behavioural model of
// the credit / round-robin rules and a payload scoreboard.
module tb_serial_link_credit_vc_sync;

    localparam int NumVc       = 2;
    localparam int NumCredits  = 8;
    localparam int DataWidth   = 32;
    localparam int CreditWidth = 4;
    localparam int VcWidth     = 1;
    localparam int Thresh      = NumCredits - 2;

    logic                            clk = 1'b0;
    logic                            rst_ni = 1'b0;
    logic [NumVc-1:0]                vc_valid;
    logic [NumVc-1:0]                vc_ready;
    logic [NumVc-1:0][DataWidth-1:0] vc_data;
    logic                            link_valid;
    logic                            link_ready;
    logic [DataWidth-1:0]            link_data;
    logic [VcWidth-1:0]              link_vc;
    logic                            link_credit_only;
    logic [VcWidth-1:0]              link_credit_vc;
    logic [CreditWidth-1:0]          link_credits;
    logic                            rx_credit_valid;
    logic [VcWidth-1:0]              rx_credit_vc;
    logic [CreditWidth-1:0]          rx_credits;
    logic [NumVc-1:0]                rx_consume;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [DataWidth-1:0] data;
        int                   vc;
        bit                   co;
        int                   cvc;
        int                   cr;
    } flit_t;

    flit_t                acc_q[$];
    logic [DataWidth-1:0] exp_q[$];

    // Model state (values after the next clock edge once updated at negedge)
    int                   m_avail[NumVc];
    int                   m_pend[NumVc];
    int                   m_rr;
    bit                   m_valid;
    logic [DataWidth-1:0] m_data;
    int                   m_vc;
    bit                   m_co;
    int                   m_cvc;
    int                   m_cr;

    serial_link_credit_vc_sync dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .vc_valid_i         (vc_valid),
        .vc_ready_o         (vc_ready),
        .vc_data_i          (vc_data),
        .link_valid_o       (link_valid),
        .link_ready_i       (link_ready),
        .link_data_o        (link_data),
        .link_vc_o          (link_vc),
        .link_credit_only_o (link_credit_only),
        .link_credit_vc_o   (link_credit_vc),
        .link_credits_o     (link_credits),
        .rx_credit_valid_i  (rx_credit_valid),
        .rx_credit_vc_i     (rx_credit_vc),
        .rx_credits_i       (rx_credits),
        .rx_consume_i       (rx_consume)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NumVc; v++) begin
            m_avail[v] = NumCredits;
            m_pend[v]  = 0;
        end
        m_rr = 0; m_valid = 0; m_data = '0; m_vc = 0; m_co = 0; m_cvc = 0; m_cr = 0;
        exp_q.delete();
    endtask

    // Advance n cycles; inputs change 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            vc_data[0] = 32'hA000_0000 | 32'(cyc);
            vc_data[1] = 32'hB000_0000 | 32'(cyc);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int sel;
        int cr;
        int grant;
        int e;
        int idx;
        bit ld_en;
        bit dl;
        bit cl;
        logic [NumVc-1:0] elig;
        logic [NumVc-1:0] exp_ready;
        flit_t f;
        if (!rst_ni) begin
            model_reset();
            check("rst vc_ready", vc_ready, 0);
            check("rst link_valid", link_valid, 0);
        end else begin
            // registered outputs against the model
            check("link_valid", link_valid, m_valid);
            if (m_valid) begin
                check("link_data", link_data, m_data);
                check("link_vc", link_vc, m_vc);
                check("link_credit_only", link_credit_only, m_co);
                check("link_credit_vc", link_credit_vc, m_cvc);
                check("link_credits", link_credits, m_cr);
            end
            check("avail0", dut.g_vc[0].u_cnt.avail_o, m_avail[0]);
            check("avail1", dut.g_vc[1].u_cnt.avail_o, m_avail[1]);
            check("pend0", dut.g_vc[0].u_cnt.pend_o, m_pend[0]);
            check("pend1", dut.g_vc[1].u_cnt.pend_o, m_pend[1]);

            // accepted flits and payload scoreboard
            if (link_valid && link_ready) begin
                f.data = link_data; f.vc = int'(link_vc); f.co = link_credit_only;
                f.cvc = int'(link_credit_vc); f.cr = int'(link_credits);
                acc_q.push_back(f);
                if (!link_credit_only) begin
                    if (exp_q.size() == 0) check("sb unexpected data flit", 1, 0);
                    else check("sb payload", link_data, exp_q.pop_front());
                end
            end

            // rules: credit choice, eligibility, round robin, load
            sel = 0;
            for (int v = 1; v < NumVc; v++) if (m_pend[v] > m_pend[sel]) sel = v;
            cr = m_pend[sel];
            for (int v = 0; v < NumVc; v++) begin
                e = m_avail[v] + ((rx_credit_valid && int'(rx_credit_vc) == v) ? int'(rx_credits) : 0);
                elig[v] = vc_valid[v] && ((e > 1) || (e == 1 && cr > 0));
            end
            grant = -1;
            for (int k = 0; k < NumVc; k++) begin
                idx = (m_rr + k) % NumVc;
                if (grant < 0 && elig[idx]) grant = idx;
            end
            ld_en = !m_valid || link_ready;
            dl = ld_en && (grant >= 0);
            cl = 0;
`ifdef SERIAL_LINK_CREDIT_FORCE_SEND_EN
            cl = ld_en && (grant < 0) && (cr >= Thresh);
`endif
            exp_ready = '0;
            if (dl) exp_ready[grant] = 1'b1;
            check("vc_ready", vc_ready, exp_ready);

            // state after the coming edge
            for (int v = 0; v < NumVc; v++) begin
                if (rx_credit_valid && int'(rx_credit_vc) == v) m_avail[v] += int'(rx_credits);
                m_pend[v] += int'(rx_consume[v]);
            end
            if (dl || cl) begin
                m_pend[sel] -= cr;
                m_valid = 1; m_co = cl; m_cvc = sel; m_cr = cr;
                m_vc   = dl ? grant : 0;
                m_data = dl ? vc_data[grant] : '0;
            end else if (ld_en) begin
                m_valid = 0;
            end
            if (dl) begin
                m_avail[grant]--;
                m_rr = (grant + 1) % NumVc;
                exp_q.push_back(vc_data[grant]);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: bench did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n0;
        int c;
        vc_valid = '0; link_ready = 1'b1; rx_credit_valid = 1'b0;
        rx_credit_vc = '0; rx_credits = '0; rx_consume = '0;
        vc_data[0] = 32'hA000_0000; vc_data[1] = 32'hB000_0000;
        model_reset();

        // reset values
        step(3);
        check("reset link_valid", link_valid, 0);
        check("reset link_data", link_data, 0);
        check("reset link_vc", link_vc, 0);
        check("reset link_credit_only", link_credit_only, 0);
        check("reset link_credit_vc", link_credit_vc, 0);
        check("reset link_credits", link_credits, 0);
        rst_ni = 1'b1;
        step(2);

        // both VCs streaming: alternate until each holds its last credit
        n0 = acc_q.size();
        vc_valid = 2'b11;
        step(20);
        vc_valid = 2'b00;
        step(2);
        check("t1 flit count", acc_q.size() - n0, 14);
        check("t1 first vc", acc_q[n0].vc, 0);
        check("t1 second vc", acc_q[n0 + 1].vc, 1);
        check("t1 third vc", acc_q[n0 + 2].vc, 0);
        check("t1 model avail0", m_avail[0], 1);
        check("t1 model avail1", m_avail[1], 1);
        check("t1 dut avail0", dut.g_vc[0].u_cnt.avail_o, 1);
        check("t1 dut avail1", dut.g_vc[1].u_cnt.avail_o, 1);

        // return the remote credits
        rx_credit_valid = 1'b1; rx_credit_vc = 1'b0; rx_credits = 4'd7;
        step(1);
        rx_credit_vc = 1'b1;
        step(1);
        rx_credit_valid = 1'b0;
        step(1);

        // VC0 alone: seven flits, the eighth waits for a credit to return
        n0 = acc_q.size();
        vc_valid = 2'b01;
        step(12);
        check("t2 withheld count", acc_q.size() - n0, 7);
        check("t2 model avail0", m_avail[0], 1);
        rx_consume = 2'b01;
        step(1);
        rx_consume = 2'b00;
        step(4);
        check("t2 total count", acc_q.size() - n0, 8);
        check("t2 8th credits", acc_q[n0 + 7].cr, 1);
        check("t2 8th credit_vc", acc_q[n0 + 7].cvc, 0);
        check("t2 8th vc", acc_q[n0 + 7].vc, 0);
        vc_valid = 2'b00;
        rx_credit_valid = 1'b1; rx_credit_vc = 1'b0; rx_credits = 4'd8;
        step(1);
        rx_credit_valid = 1'b0;
        step(1);

        // no data, six freed entries on VC1
        n0 = acc_q.size();
        for (int i = 0; i < 6; i++) begin
            rx_consume = 2'b10;
            step(1);
        end
        rx_consume = 2'b00;
        step(3);
`ifdef SERIAL_LINK_CREDIT_FORCE_SEND_EN
        check("t3 credit flit count", acc_q.size() - n0, 1);
        check("t3 credit_only", acc_q[n0].co, 1);
        check("t3 credit_vc", acc_q[n0].cvc, 1);
        check("t3 credits", acc_q[n0].cr, 6);
        check("t3 data", acc_q[n0].data, 0);
        check("t3 model avail1", m_avail[1], 8);
        check("t3 dut avail1", dut.g_vc[1].u_cnt.avail_o, 8);
`else
        check("t3 no flit", acc_q.size() - n0, 0);
        check("t3 model pend1", m_pend[1], 6);
        check("t3 dut pend1", dut.g_vc[1].u_cnt.pend_o, 6);
`endif

        // held flit while credits accumulate
        n0 = acc_q.size();
        c = cyc;
        link_ready = 1'b0;
        vc_valid = 2'b10;
        step(1);
        rx_consume = 2'b01;
        step(5);
        rx_consume = 2'b00;
        check("t4 held valid", link_valid, 1);
        check("t4 held data", link_data, 32'hB000_0000 | 32'(c));
        check("t4 held vc", link_vc, 1);
`ifdef SERIAL_LINK_CREDIT_FORCE_SEND_EN
        check("t4 held credits", link_credits, 0);
        check("t4 held credit_vc", link_credit_vc, 0);
`else
        check("t4 held credits", link_credits, 6);
        check("t4 held credit_vc", link_credit_vc, 1);
`endif
        link_ready = 1'b1;
        step(1);
        vc_valid = 2'b00;
        step(3);
        check("t4 flit count", acc_q.size() - n0, 2);
        check("t4 next data", acc_q[n0 + 1].data, 32'hB000_0000 | 32'(c + 6));
        check("t4 next credits", acc_q[n0 + 1].cr, 5);
        check("t4 next credit_vc", acc_q[n0 + 1].cvc, 0);
        check("t4 model avail1", m_avail[1], 6);

        // data load and returned credits on the same VC in one cycle
        vc_valid = 2'b01;
        step(3);
        check("t5 model avail0 before", m_avail[0], 5);
        check("t5 dut avail0 before", dut.g_vc[0].u_cnt.avail_o, 5);
        rx_credit_valid = 1'b1; rx_credit_vc = 1'b0; rx_credits = 4'd3;
        #1;
        check("t5 ready same cycle", vc_ready, 2'b01);
        step(1);
        rx_credit_valid = 1'b0;
        vc_valid = 2'b00;
        check("t5 model avail0 after", m_avail[0], 7);
        check("t5 dut avail0 after", dut.g_vc[0].u_cnt.avail_o, 7);
        step(2);

        // reset while a flit is held
        link_ready = 1'b0;
        vc_valid = 2'b01;
        step(2);
        check("t6 held before reset", link_valid, 1);
        rst_ni = 1'b0;
        #1;
        check("t6 valid in reset", link_valid, 0);
        check("t6 ready in reset", vc_ready, 0);
        step(1);
        check("t6 dut avail0", dut.g_vc[0].u_cnt.avail_o, 8);
        check("t6 dut avail1", dut.g_vc[1].u_cnt.avail_o, 8);
        check("t6 dut pend0", dut.g_vc[0].u_cnt.pend_o, 0);
        check("t6 link_credits", link_credits, 0);
        rst_ni = 1'b1;
        vc_valid = 2'b00;
        link_ready = 1'b1;
        step(1);
        n0 = acc_q.size();
        vc_valid = 2'b11;
        step(3);
        vc_valid = 2'b00;
        step(2);
        check("t6 restart count", acc_q.size() - n0, 3);
        check("t6 restart first vc", acc_q[n0].vc, 0);
        check("t6 restart second vc", acc_q[n0 + 1].vc, 1);
        check("sb drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
